pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 116 +++++++++++
 tb/tb_pipeline_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Hazard/stall controller for a 5-stage pipeline: stage enables, bubble
// injection, sticky halt and saturating stall/flush performance counters.
module pipeline_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             branch_taken,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, REFETCH, HALTED} state_e;

  state_e           state_q, state_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             dwait, lu;

  assign dwait = dmem_req & ~dhit;
  assign lu    = ex_memread & (ex_wsel != 5'd0) &
                 ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;
    halt_d     = halt_q;
    flush_inc  = 1'b0;
    stall_inc  = 1'b0;

    if (!nRST || state_q == HALTED) begin
      // Reset forces everything quiet immediately; HALTED freezes the pipe.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (dwait) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_halt) begin
      // Let the halt retire through MEM/WB, freeze everything upstream.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      state_d  = HALTED;
      halt_d   = 1'b1;
    end else if (state_q == REFETCH) begin
      // The in-flight fetch targets the wrong path; drop it when it lands.
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      if (ihit) state_d = RUN;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
      state_d    = ihit ? RUN : REFETCH;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end

    stall_inc = nRST && (state_q != HALTED) && !pc_en;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: a reference model pushes expected
// outputs per cycle, a negedge monitor pops and compares against the DUT.
module tb_pipeline_controller;
  localparam int CNT_W = 4;

  logic CLK = 1'b0, nRST = 1'b0;
  logic ihit = 0, dhit = 0, dmem_req = 0, ex_memread = 0, id_uses_rt = 0;
  logic branch_taken = 0, mem_halt = 0;
  logic [4:0] ex_wsel = 0, id_rs = 0, id_rt = 0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_controller #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .ex_memread(ex_memread), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .mem_halt(mem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [6:0] o;
    logic       h;
    logic [3:0] s;
    logic [3:0] f;
  } exp_t;

  exp_t sbq[$];
  int total = 0, bad = 0;

  // model state: 0 RUN, 1 REFETCH, 2 HALTED
  int         mst;
  logic       mhalt;
  logic [3:0] mstall, mflush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
  endfunction

  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("outs", {25'd0, outs()}, {25'd0, e.o});
      chk("halt", {31'd0, halt}, {31'd0, e.h});
      chk("stall_cnt", {28'd0, stall_cnt}, {28'd0, e.s});
      chk("flush_cnt", {28'd0, flush_cnt}, {28'd0, e.f});
    end
  end

  // Reference: compute this cycle's expected outputs, push them with the
  // pre-edge register values, then advance the model across the edge.
  task automatic model_step();
    exp_t e;
    logic dw, l, st_inc, fl_inc;
    logic [6:0] o;
    dw = dmem_req && !dhit;
    l  = ex_memread && ex_wsel != 0 &&
         (ex_wsel == id_rs || (id_uses_rt && ex_wsel == id_rt));
    st_inc = 0; fl_inc = 0;
    if (mst == 2)                   o = 7'b0000000;
    else if (dw)                    begin o = 7'b0000000; st_inc = 1; end
    else if (mem_halt)              begin o = 7'b0000100; st_inc = 1; end
    else if (mst == 1)              begin o = 7'b0111110; st_inc = 1; end
    else if (branch_taken)          begin o = 7'b1111111; fl_inc = 1; end
    else if (l)                     begin o = 7'b0011101; st_inc = 1; end
    else if (!ihit)                 begin o = 7'b0111110; st_inc = 1; end
    else                            o = 7'b1111100;
    e.o = o; e.h = mhalt; e.s = mstall; e.f = mflush;
    sbq.push_back(e);
    if (st_inc && mstall != 4'hf) mstall = mstall + 1;
    if (fl_inc && mflush != 4'hf) mflush = mflush + 1;
    if (mst != 2) begin
      if (dw) ;
      else if (mem_halt) begin mst = 2; mhalt = 1; end
      else if (mst == 1) begin if (ihit) mst = 0; end
      else if (branch_taken && !ihit) mst = 1;
    end
  endtask

  task automatic cyc(input logic ih, input logic dr, input logic dh,
                     input logic exm, input logic [4:0] ews, input logic [4:0] rs,
                     input logic [4:0] rt, input logic urt, input logic br,
                     input logic mh);
    ihit = ih; dmem_req = dr; dhit = dh; ex_memread = exm; ex_wsel = ews;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; branch_taken = br; mem_halt = mh;
    model_step();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    nRST = 0;
    #2;
    chk("rst_outs", {25'd0, outs()}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_cnts", {24'd0, stall_cnt, flush_cnt}, 32'd0);
    mst = 0; mhalt = 0; mstall = 0; mflush = 0;
    @(posedge CLK); #1;
    nRST = 1;
  endtask

  initial begin
    #1;
    do_reset();

    // load-use on rs, then free-running
    cyc(1, 0, 0, 1, 5, 5, 0, 0, 0, 0);
    idle();
    chk("lu_stall", {28'd0, stall_cnt}, 32'd1);

    // zero register and rt-path hazards
    do_reset();
    cyc(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 7, 3, 7, 1, 0, 0);
    cyc(1, 0, 0, 1, 7, 3, 7, 0, 0, 0);
    chk("rt_stall", {28'd0, stall_cnt}, 32'd1);

    // branch with fetch pending; lu during REFETCH is ignored
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 4, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("br_flush", {28'd0, flush_cnt}, 32'd1);
    chk("br_stall", {28'd0, stall_cnt}, 32'd3);

    // dwait over load-use
    do_reset();
    repeat (3) cyc(1, 1, 0, 1, 5, 5, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 5, 5, 0, 0, 0, 0);
    idle();
    chk("dw_stall", {28'd0, stall_cnt}, 32'd4);

    // reset from REFETCH lands in RUN
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset();
    idle();

    // halt beats branch
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 1, 5, 5, 0, 0, 1, 0);
    chk("halt_sticky", {31'd0, halt}, 32'd1);
    chk("halt_flush", {28'd0, flush_cnt}, 32'd0);
    do_reset();
    idle();

    // saturation
    do_reset();
    repeat (20) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
    repeat (17) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_sat", {28'd0, flush_cnt}, 32'd15);
    chk("stall_hold", {28'd0, stall_cnt}, 32'd15);

    // random traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 99) == 0);
      if (i % 60 == 59) do_reset();
    end

    @(negedge CLK); #1;
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
